// File: rtl/alu_share_arbiter.sv
// Two-requester shared ALU: round-robin valid/ready arbitration, multi-cycle MUL,
// and a held, tagged result behind a valid/ready output handshake.
module alu_share_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int MUL_LATENCY = 3
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic                  Req0Valid,
   output logic                  Req0Ready,
   input  logic [3:0]            Req0Control,
   input  logic [DATA_WIDTH-1:0] Req0A,
   input  logic [DATA_WIDTH-1:0] Req0B,
   input  logic                  Req1Valid,
   output logic                  Req1Ready,
   input  logic [3:0]            Req1Control,
   input  logic [DATA_WIDTH-1:0] Req1A,
   input  logic [DATA_WIDTH-1:0] Req1B,
   output logic                  ResultValid,
   input  logic                  ResultReady,
   output logic [DATA_WIDTH-1:0] Result,
   output logic                  ResultId,
   output logic                  Zero
);

   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 1);
   localparam logic [3:0] OP_MUL   = 4'b0011;

   state_t                  state;
   logic [3:0]              count;
   logic                    last_grant;
   logic [3:0]              op_ctrl;
   logic [DATA_WIDTH-1:0]   op_a;
   logic [DATA_WIDTH-1:0]   op_b;
   logic                    op_id;

   logic                    can_accept;
   logic                    accept;
   logic                    grant1;
   logic [3:0]              sel_ctrl;
   logic [DATA_WIDTH-1:0]   sel_a;
   logic [DATA_WIDTH-1:0]   sel_b;
   logic [DATA_WIDTH-1:0]   sel_result;
   logic [DATA_WIDTH-1:0]   exec_result;
   logic                    sel_mul_wait;

   function automatic logic [DATA_WIDTH-1:0] alu(input logic [3:0] ctrl,
                                                 input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH-1:0] r;
      case (ctrl)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b0010: r = a + b;
         4'b0011: r = a * b;
         4'b0110: r = a - b;
         4'b0111: r = ($signed(a) < $signed(b)) ? DATA_WIDTH'(1) : '0;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Ready is gated by Rst_n so it reads 0 throughout reset, even with requests pending.
   always_comb begin
      can_accept   = Rst_n && ((state == IDLE) || ((state == HOLD) && ResultReady));
      Req0Ready    = can_accept && Req0Valid && (!Req1Valid || last_grant);
      Req1Ready    = can_accept && Req1Valid && (!Req0Valid || !last_grant);
      accept       = Req0Ready || Req1Ready;
      grant1       = Req1Ready;
      sel_ctrl     = grant1 ? Req1Control : Req0Control;
      sel_a        = grant1 ? Req1A : Req0A;
      sel_b        = grant1 ? Req1B : Req0B;
      sel_result   = alu(sel_ctrl, sel_a, sel_b);
      sel_mul_wait = (sel_ctrl == OP_MUL) && (MUL_LATENCY > 1);
      exec_result  = alu(op_ctrl, op_a, op_b);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state       <= IDLE;
         count       <= '0;
         last_grant  <= 1'b1;
         op_ctrl     <= '0;
         op_a        <= '0;
         op_b        <= '0;
         op_id       <= 1'b0;
         ResultValid <= 1'b0;
         Result      <= '0;
         ResultId    <= 1'b0;
         Zero        <= 1'b0;
      end else begin
         case (state)
            IDLE, HOLD: begin
               if (accept) begin
                  last_grant <= grant1;
                  op_ctrl    <= sel_ctrl;
                  op_a       <= sel_a;
                  op_b       <= sel_b;
                  op_id      <= grant1;
                  if (sel_mul_wait) begin
                     state       <= EXEC;
                     count       <= CNT_LOAD;
                     ResultValid <= 1'b0;
                  end else begin
                     state       <= HOLD;
                     ResultValid <= 1'b1;
                     Result      <= sel_result;
                     ResultId    <= grant1;
                     Zero        <= (sel_result == '0);
                  end
               end else if ((state == HOLD) && ResultReady) begin
                  state       <= IDLE;
                  ResultValid <= 1'b0;
               end
            end
            EXEC: begin
               if (count == 4'd1) begin
                  state       <= HOLD;
                  count       <= '0;
                  ResultValid <= 1'b1;
                  Result      <= exec_result;
                  ResultId    <= op_id;
                  Zero        <= (exec_result == '0);
               end else begin
                  count <= count - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter against a transaction-level model.
module tb_alu_share_arbiter;

   localparam int DW = 32;
   localparam int ML = 3;

   logic          Clk = 1'b0;
   logic          Rst_n;
   logic          Req0Valid, Req1Valid, Req0Ready, Req1Ready;
   logic [3:0]    Req0Control, Req1Control;
   logic [DW-1:0] Req0A, Req0B, Req1A, Req1B;
   logic          ResultValid, ResultReady, ResultId, Zero;
   logic [DW-1:0] Result;

   int unsigned   tests = 0;
   int unsigned   failed = 0;

   // Model: visible result, who won last tie, and a MUL countdown to its result edge.
   logic          m_valid, m_id, m_zero, m_last, m_pid;
   logic [DW-1:0] m_res, m_pres;
   int            m_wait;

   alu_share_arbiter #(.DATA_WIDTH(DW), .MUL_LATENCY(ML)) dut (
      .Clk(Clk), .Rst_n(Rst_n),
      .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Control(Req0Control),
      .Req0A(Req0A), .Req0B(Req0B),
      .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Control(Req1Control),
      .Req1A(Req1A), .Req1B(Req1B),
      .ResultValid(ResultValid), .ResultReady(ResultReady), .Result(Result),
      .ResultId(ResultId), .Zero(Zero)
   );

   always #5 Clk = ~Clk;

   function automatic logic [DW-1:0] ref_alu(input logic [3:0] c, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      case (c)
         4'd0: return a & b;
         4'd1: return a | b;
         4'd2: return a + b;
         4'd3: return a * b;
         4'd6: return a - b;
         4'd7: return ($signed(a) < $signed(b)) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_id = 0; m_zero = 0; m_last = 1; m_res = '0;
      m_wait = 0; m_pres = '0; m_pid = 0;
   endtask

   // Called at a negedge: drive, compare one cycle, advance model, move to next negedge.
   task automatic step(input logic v0, input logic [3:0] c0, input logic [DW-1:0] a0,
                       input logic [DW-1:0] b0, input logic v1, input logic [3:0] c1,
                       input logic [DW-1:0] a1, input logic [DW-1:0] b1, input logic rr);
      logic win, g, e0, e1;
      logic [DW-1:0] r;
      Req0Valid = v0; Req0Control = c0; Req0A = a0; Req0B = b0;
      Req1Valid = v1; Req1Control = c1; Req1A = a1; Req1B = b1;
      ResultReady = rr;
      #1;
      win = (!m_valid && m_wait == 0) || (m_valid && rr);
      g   = (v0 && v1) ? !m_last : v1;
      e0  = win && v0 && !g;
      e1  = win && v1 && g;
      chk("req0_ready", Req0Ready, e0);
      chk("req1_ready", Req1Ready, e1);
      chk("result_valid", ResultValid, m_valid);
      if (m_valid) begin
         chk("result", Result, m_res);
         chk("result_id", ResultId, m_id);
         chk("zero", Zero, m_zero);
      end
      if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) begin
            m_valid = 1; m_res = m_pres; m_id = m_pid; m_zero = (m_pres == 0);
         end
      end else if (e0 || e1) begin
         m_last = g;
         r = g ? ref_alu(c1, a1, b1) : ref_alu(c0, a0, b0);
         if (((g ? c1 : c0) == 4'd3) && ML > 1) begin
            m_wait = ML - 1; m_valid = 0; m_pres = r; m_pid = g;
         end else begin
            m_valid = 1; m_res = r; m_id = g; m_zero = (r == 0);
         end
      end else if (m_valid && rr) begin
         m_valid = 0;
      end
      @(posedge Clk);
      @(negedge Clk);
   endtask

   task automatic idle(input logic rr);
      step(0, 4'd0, '0, '0, 0, 4'd0, '0, '0, rr);
   endtask

   initial begin
      logic [3:0] codes [7];
      logic [3:0] c0, c1;
      codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd15};
      model_reset();
      Rst_n = 0;
      Req0Valid = 1; Req1Valid = 1; ResultReady = 1;
      Req0Control = 0; Req1Control = 0; Req0A = 0; Req0B = 0; Req1A = 0; Req1B = 0;
      @(negedge Clk); @(negedge Clk);
      #1;
      chk("rst_valid", ResultValid, 0);
      chk("rst_result", Result, 0);
      chk("rst_id", ResultId, 0);
      chk("rst_zero", Zero, 0);
      chk("rst_ready0", Req0Ready, 0);
      chk("rst_ready1", Req1Ready, 0);
      @(negedge Clk);
      Rst_n = 1;

      // ADD 5+7 from requester 0
      step(1, 4'd2, 5, 7, 0, 4'd0, 0, 0, 1);
      chk("add_result", Result, 12);
      chk("add_id", ResultId, 0);
      chk("add_valid", ResultValid, 1);
      idle(1);
      chk("add_one_cycle", ResultValid, 0);

      // MUL 6*7 from requester 1; requester 0 blocked during EXEC
      step(0, 4'd0, 0, 0, 1, 4'd3, 6, 7, 1);
      step(1, 4'd2, 1, 1, 0, 4'd0, 0, 0, 1);
      step(1, 4'd2, 1, 1, 0, 4'd0, 0, 0, 1);
      chk("mul_valid", ResultValid, 1);
      chk("mul_result", Result, 42);
      chk("mul_id", ResultId, 1);
      step(1, 4'd2, 1, 1, 0, 4'd0, 0, 0, 1);
      idle(1);

      // Both valid each cycle: grants alternate, starting with 1 (last grant was 0)
      for (int k = 0; k < 6; k++) begin
         step(1, 4'd6, 3, 3, 1, 4'd7, 32'hFFFF_FFFF, 1, 1);
         chk("alt_id", ResultId, (k % 2 == 0) ? 1 : 0);
         chk("alt_result", Result, (k % 2 == 0) ? 1 : 0);
         chk("alt_zero", Zero, (k % 2 == 0) ? 0 : 1);
      end
      idle(1);

      // Held result under back-pressure
      step(1, 4'd1, 32'hF0, 32'h0F, 0, 4'd0, 0, 0, 1);
      for (int k = 0; k < 4; k++) begin
         chk("hold_result", Result, 32'hFF);
         step(1, 4'd2, 1, 2, 1, 4'd2, 3, 4, 0);
      end
      chk("hold_valid", ResultValid, 1);
      step(1, 4'd2, 1, 2, 1, 4'd2, 3, 4, 1);
      chk("resume_result", Result, 7);
      idle(1);

      // Reset one cycle into a MUL
      step(0, 4'd0, 0, 0, 1, 4'd3, 3, 4, 1);
      idle(1);
      Rst_n = 0;
      Req0Valid = 1; Req1Valid = 1;
      #1;
      chk("midrst_valid", ResultValid, 0);
      chk("midrst_ready0", Req0Ready, 0);
      chk("midrst_ready1", Req1Ready, 0);
      model_reset();
      @(negedge Clk);
      Rst_n = 1;
      idle(1);
      idle(1);
      step(1, 4'd2, 2, 2, 1, 4'd2, 8, 8, 1);
      chk("postrst_id", ResultId, 0);
      chk("postrst_result", Result, 4);
      idle(1);

      // Undefined code
      step(0, 4'd0, 0, 0, 1, 4'b1111, 9, 9, 1);
      chk("undef_valid", ResultValid, 1);
      chk("undef_result", Result, 0);
      chk("undef_zero", Zero, 1);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         c0 = codes[$urandom_range(0, 6)];
         c1 = codes[$urandom_range(0, 6)];
         if ($urandom_range(0, 7) == 0) c0 = 4'($urandom_range(0, 15));
         step($urandom_range(0, 1) == 1, c0,
              ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : $urandom(), $urandom(),
              $urandom_range(0, 1) == 1, c1,
              $urandom(), ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 3)) : $urandom(),
              $urandom_range(0, 3) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
